// File: rtl/risc_pkg.sv
// Shared encodings for the risc fetch sequencer and the ctrl block:
// branch selector codes and the fetch FSM state encoding.
package risc_pkg;

  typedef enum logic [1:0] {
    BR_SEQ  = 2'b00,
    BR_ABS  = 2'b01,
    BR_REL  = 2'b10,
    BR_CALL = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/risc_fetch_seq_if.sv
// Instruction-memory fetch handshake: the sequencer is the master, and the
// memory answers with ready and read data in the same cycle.
interface risc_fetch_seq_if #(
  parameter int XLEN = 16
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/risc_next_pc.sv
// Combinational next-PC resolution: sequential, absolute, conditional relative and call.
// All arithmetic wraps modulo 2^XLEN.
module risc_next_pc
  import risc_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int IMM_W = 7
) (
  input  logic [XLEN-1:0]  pc,
  input  logic [1:0]       branch,
  input  logic [XLEN-1:0]  br_target,
  input  logic [IMM_W-1:0] br_imm,
  input  logic             br_cond,
  output logic [XLEN-1:0]  seq_pc,
  output logic [XLEN-1:0]  next_pc
);

  logic [XLEN-1:0] imm_sext_s;

  assign seq_pc     = pc + {{(XLEN-1){1'b0}}, 1'b1};
  assign imm_sext_s = {{(XLEN-IMM_W){br_imm[IMM_W-1]}}, br_imm};

  // Target selection by branch kind
  always_comb begin
    next_pc = seq_pc;
    case (branch_e'(branch))
      BR_SEQ:  next_pc = seq_pc;
      BR_ABS:  next_pc = br_target;
      BR_REL: begin
        if (br_cond) begin
          next_pc = seq_pc + imm_sext_s;
        end else begin
          next_pc = seq_pc;
        end
      end
      BR_CALL: next_pc = br_target;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/risc_fetch_seq.sv
// Multi-cycle instruction fetch / PC sequencer: FETCH over the imem handshake,
// hold IR in EXEC until ex_done, then commit halt, interrupt entry or branch.
module risc_fetch_seq
  import risc_pkg::*;
#(
  parameter int              XLEN       = 16,
  parameter int              IMM_W      = 7,
  parameter logic [XLEN-1:0] PROG_START = 16'h000F,
  parameter logic [XLEN-1:0] IRQ_VECTOR = 16'h0004
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_fetch_seq_if.master     imem,
  output logic [XLEN-1:0]      ir,
  output logic                 ir_valid,
  input  logic                 ex_done,
  input  logic [1:0]           branch,
  input  logic [XLEN-1:0]      br_target,
  input  logic [IMM_W-1:0]     br_imm,
  input  logic                 br_cond,
  input  logic                 halt,
  input  logic                 irq,
  input  logic                 irq_reen,
  output logic                 irq_ack,
  output logic [XLEN-1:0]      epc,
  output logic [XLEN-1:0]      link_pc,
  output logic                 link_we,
  output logic [XLEN-1:0]      pc,
  output logic                 halted
);

  state_e          state_r;
  state_e          state_nx_s;
  logic            irq_en_r;
  logic            fetch_xfer_s;
  logic            commit_s;
  logic            do_halt_s;
  logic            take_irq_s;
  logic            do_link_s;
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] next_pc_s;

  risc_next_pc #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_next_pc (
    .pc        (pc),
    .branch    (branch),
    .br_target (br_target),
    .br_imm    (br_imm),
    .br_cond   (br_cond),
    .seq_pc    (seq_pc_s),
    .next_pc   (next_pc_s)
  );

  assign imem.imem_addr = pc;

  // Halt outranks interrupt; the call link write survives interrupt entry
  assign do_halt_s  = commit_s && halt;
  assign take_irq_s = commit_s && !halt && irq && irq_en_r;
  assign do_link_s  = commit_s && !halt && (branch_e'(branch) == BR_CALL);

  // Next-state and handshake decode
  always_comb begin
    state_nx_s   = state_r;
    fetch_xfer_s = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (imem.imem_req && imem.imem_ready) begin
          fetch_xfer_s = 1'b1;
          state_nx_s   = ST_EXEC;
        end else begin
          state_nx_s   = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          commit_s   = 1'b1;
          state_nx_s = halt ? ST_HALTED : ST_FETCH;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_HALTED: state_nx_s = ST_HALTED;
      default:   state_nx_s = ST_FETCH;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Architectural registers; req/ir_valid are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= PROG_START;
      ir            <= {XLEN{1'b0}};
      epc           <= {XLEN{1'b0}};
      link_pc       <= {XLEN{1'b0}};
      ir_valid      <= 1'b0;
      imem.imem_req <= 1'b0;
      irq_ack       <= 1'b0;
      link_we       <= 1'b0;
      halted        <= 1'b0;
      irq_en_r      <= 1'b1;
    end else begin
      imem.imem_req <= (state_nx_s == ST_FETCH);
      ir_valid      <= (state_nx_s == ST_EXEC);
      irq_ack       <= take_irq_s;
      link_we       <= do_link_s;
      if (fetch_xfer_s) begin
        ir <= imem.imem_rdata;
      end
      if (do_link_s) begin
        link_pc <= seq_pc_s;
      end
      if (do_halt_s) begin
        pc     <= seq_pc_s;
        halted <= 1'b1;
      end else if (take_irq_s) begin
        epc      <= next_pc_s;
        pc       <= IRQ_VECTOR;
        irq_en_r <= 1'b0;
      end else if (commit_s) begin
        pc <= next_pc_s;
        if (irq_reen) begin
          irq_en_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc_fetch_seq.sv
// Directed self-checking bench for risc_fetch_seq; instruction memory returns addr ^ A5A5.
module tb_risc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ex_done;
  logic [1:0]  branch;
  logic [15:0] br_target;
  logic [6:0]  br_imm;
  logic        br_cond;
  logic        halt;
  logic        irq;
  logic        irq_reen;
  logic        irq_ack;
  logic [15:0] epc;
  logic [15:0] link_pc;
  logic        link_we;
  logic [15:0] pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  risc_fetch_seq_if #(.XLEN(16)) bus ();

  assign bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;

  always #5 clk = ~clk;

  risc_fetch_seq dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (bus),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ex_done   (ex_done),
    .branch    (branch),
    .br_target (br_target),
    .br_imm    (br_imm),
    .br_cond   (br_cond),
    .halt      (halt),
    .irq       (irq),
    .irq_reen  (irq_reen),
    .irq_ack   (irq_ack),
    .epc       (epc),
    .link_pc   (link_pc),
    .link_we   (link_we),
    .pc        (pc),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
  endtask

  task automatic do_exec(input logic [1:0] br, input logic [15:0] tgt, input logic [6:0] imm,
                         input logic cond, input logic hlt, input logic rq, input logic reen);
    branch = br; br_target = tgt; br_imm = imm; br_cond = cond;
    halt = hlt; irq = rq; irq_reen = reen; ex_done = 1'b1;
    tick();
    ex_done = 1'b0; halt = 1'b0; irq = 1'b0; irq_reen = 1'b0;
    branch = 2'b00; br_target = 16'h0000; br_imm = 7'h00; br_cond = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus.imem_ready = 1'b0; ex_done = 1'b0; branch = 2'b00;
    br_target = 16'h0000; br_imm = 7'h00; br_cond = 1'b0;
    halt = 1'b0; irq = 1'b0; irq_reen = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 16'h000F);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_req", {15'd0, bus.imem_req}, 16'h0000);
    chk("rst_irv", {15'd0, ir_valid}, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk("rst_epc", epc, 16'h0000);
    chk("rst_link", link_pc, 16'h0000);
    chk("rst_pulses", {14'd0, irq_ack, link_we}, 16'h0000);

    // 1: back-to-back sequential fetch, two cycles per instruction
    rst = 1'b1; bus.imem_ready = 1'b1; ex_done = 1'b1;
    tick();
    chk("t1_req0", {15'd0, bus.imem_req}, 16'h0001);
    chk("t1_addr0", bus.imem_addr, 16'h000F);
    tick();
    chk("t1_ir0", ir, 16'hA5AA);
    chk("t1_irv0", {15'd0, ir_valid}, 16'h0001);
    chk("t1_req_ex", {15'd0, bus.imem_req}, 16'h0000);
    tick();
    chk("t1_addr1", bus.imem_addr, 16'h0010);
    tick();
    chk("t1_ir1", ir, 16'hA5B5);
    tick();
    chk("t1_addr2", bus.imem_addr, 16'h0011);
    tick();
    chk("t1_ir2", ir, 16'hA5B4);

    // 2: memory stalls three cycles, request and address held
    tick();
    ex_done = 1'b0; bus.imem_ready = 1'b0;
    chk("t2_req_a", {15'd0, bus.imem_req}, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req_hold", {15'd0, bus.imem_req}, 16'h0001);
      chk("t2_addr_hold", bus.imem_addr, 16'h0012);
      chk("t2_ir_hold", ir, 16'hA5B4);
    end
    do_fetch();
    chk("t2_ir_cap", ir, 16'hA5B7);
    chk("t2_irv", {15'd0, ir_valid}, 16'h0001);
    do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_pc", pc, 16'h0013);

    // 3: relative branches and wrap-around
    do_fetch(); do_exec(2'b01, 16'h0020, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_abs", pc, 16'h0020);
    do_fetch(); do_exec(2'b10, 16'h0000, 7'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_taken", pc, 16'h001F);
    do_fetch(); do_exec(2'b01, 16'h0020, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(); do_exec(2'b10, 16'h0000, 7'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_not", pc, 16'h0021);
    do_fetch(); do_exec(2'b10, 16'h0000, 7'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_maxpos", pc, 16'h0061);
    do_fetch(); do_exec(2'b01, 16'hFFFF, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(); do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_seq_wrap", pc, 16'h0000);
    do_fetch(); do_exec(2'b01, 16'hFFFF, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(); do_exec(2'b10, 16'h0000, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_wrap", pc, 16'hFFFF);

    // 4: call with link
    do_fetch(); do_exec(2'b01, 16'h0030, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(); do_exec(2'b11, 16'h0100, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_pc", pc, 16'h0100);
    chk("t4_link", link_pc, 16'h0031);
    chk("t4_we_on", {15'd0, link_we}, 16'h0001);
    do_fetch();
    chk("t4_we_off", {15'd0, link_we}, 16'h0000);

    // 5: interrupt entry, masking, re-enable
    do_exec(2'b01, 16'h0200, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_pc", pc, 16'h0004);
    chk("t5_epc", epc, 16'h0200);
    chk("t5_ack_on", {15'd0, irq_ack}, 16'h0001);
    do_fetch();
    chk("t5_ack_off", {15'd0, irq_ack}, 16'h0000);
    do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_masked_pc", pc, 16'h0005);
    chk("t5_masked_ack", {15'd0, irq_ack}, 16'h0000);
    do_fetch(); do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_reen_pc", pc, 16'h0006);
    chk("t5_reen_epc", epc, 16'h0200);
    do_fetch(); do_exec(2'b11, 16'h0300, 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_irq2_pc", pc, 16'h0004);
    chk("t5_irq2_epc", epc, 16'h0300);
    chk("t5_irq2_link", {15'd0, link_we}, 16'h0001);
    chk("t5_irq2_linkpc", link_pc, 16'h0007);

    // 6: halt wins over interrupt, then reset recovery
    do_fetch(); do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_fetch(); do_exec(2'b01, 16'h0040, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(); do_exec(2'b00, 16'h0000, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_halted", {15'd0, halted}, 16'h0001);
    chk("t6_pc", pc, 16'h0041);
    chk("t6_no_ack", {15'd0, irq_ack}, 16'h0000);
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_req", {15'd0, bus.imem_req}, 16'h0000);
      chk("t6_no_irv", {15'd0, ir_valid}, 16'h0000);
    end
    bus.imem_ready = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t6_rst_pc", pc, 16'h000F);
    chk("t6_rst_halted", {15'd0, halted}, 16'h0000);
    tick();
    chk("t6_req_after_rst", {15'd0, bus.imem_req}, 16'h0001);
    do_fetch();
    chk("t6_exec", {15'd0, ir_valid}, 16'h0001);
    rst = 1'b0; ex_done = 1'b1; branch = 2'b11; br_target = 16'h0500; irq = 1'b1;
    tick();
    rst = 1'b1; ex_done = 1'b0; branch = 2'b00; br_target = 16'h0000; irq = 1'b0;
    chk("t6_midex_pc", pc, 16'h000F);
    chk("t6_midex_pulses", {14'd0, irq_ack, link_we}, 16'h0000);
    chk("t6_midex_link", link_pc, 16'h0000);
    chk("t6_midex_irv", {15'd0, ir_valid}, 16'h0000);
    tick();
    chk("t6_fetch_next", {15'd0, bus.imem_req}, 16'h0001);
    chk("t6_fetch_addr", bus.imem_addr, 16'h000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
